// File: rtl/timer_rd_port.sv
// Read-side APB responder for the 64-bit timer: TDR0/TDR1/SNAP with wait states
// and an upper-half shadow that keeps a TDR0-then-TDR1 read pair coherent.
module timer_rd_port #(
  parameter int unsigned WAIT_STATES = 1,
  localparam int unsigned ADDR_W = 12,
  localparam int unsigned CNT_W  = 64,
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              cnt_clr,
  input  logic              tdr_wr_sel,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              snap_valid
);

  localparam int unsigned WCNT_W = 3;
  localparam int unsigned OFF_W  = ADDR_W - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OFF_W-1:0] OFF_TDR0 = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_TDR1 = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_SNAP = OFF_W'(2);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_STATES);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_capture;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_rdata;
  logic              w_err;
  logic              w_unused_addr;

  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;
  logic              r_snap_valid;
  logic [DATA_W-1:0] r_hi_shadow;

  assign w_off         = paddr[ADDR_W-1:2];
  assign w_unused_addr = ^paddr[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Next state and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel && !penable && !pwrite) begin
          if (WAIT_STATES == 32'd0) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_wcnt_nxt  = WAIT_LD;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          w_wcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          if (r_wcnt != '0) begin
            w_wcnt_nxt = r_wcnt - WCNT_W'(1);
          end
          if (r_wcnt == WCNT_W'(1)) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Read mux, evaluated on pre-edge counter and shadow values
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_off)
      OFF_TDR0: w_rdata = cnt[DATA_W-1:0];
      OFF_TDR1: w_rdata = r_snap_valid ? r_hi_shadow : cnt[CNT_W-1:DATA_W];
      OFF_SNAP: w_rdata = {(DATA_W-1)'(0), r_snap_valid};
      default:  w_err   = 1'b1;
    endcase
  end

  // Response registers; pslverr only lives in the pready cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_capture;
      r_pslverr <= w_capture & w_err;
      if (w_capture) begin
        r_prdata <= w_rdata;
      end
    end
  end

  // Shadow maintenance: clear beats write strobe beats read side effects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_shadow  <= '0;
      r_snap_valid <= 1'b0;
    end else if (cnt_clr) begin
      r_hi_shadow  <= '0;
      r_snap_valid <= 1'b0;
    end else if (tdr_wr_sel) begin
      r_snap_valid <= 1'b0;
    end else if (w_capture) begin
      if (w_off == OFF_TDR0) begin
        r_hi_shadow  <= cnt[CNT_W-1:DATA_W];
        r_snap_valid <= 1'b1;
      end else if (w_off == OFF_TDR1) begin
        r_snap_valid <= 1'b0;
      end
    end
  end

  assign prdata     = r_prdata;
  assign pready     = r_pready;
  assign pslverr    = r_pslverr;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_timer_rd_port.sv
// Bench for timer_rd_port: three instances (0, 1 and 3 wait states) sharing the
// APB bus, each selected by its own psel, checked against a read-side model.
module tb_timer_rd_port;

  logic        clk;
  logic        rst_n;
  logic        psel_v [3];
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [63:0] cnt;
  logic        cnt_clr;
  logic        tdr_wr_sel;
  logic [31:0] prdata_o [3];
  logic        pready_o [3];
  logic        pslverr_o [3];
  logic        snap_o [3];

  timer_rd_port #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .cnt(cnt), .cnt_clr(cnt_clr), .tdr_wr_sel(tdr_wr_sel),
    .prdata(prdata_o[0]), .pready(pready_o[0]), .pslverr(pslverr_o[0]), .snap_valid(snap_o[0]));

  timer_rd_port #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .cnt(cnt), .cnt_clr(cnt_clr), .tdr_wr_sel(tdr_wr_sel),
    .prdata(prdata_o[1]), .pready(pready_o[1]), .pslverr(pslverr_o[1]), .snap_valid(snap_o[1]));

  timer_rd_port #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .cnt(cnt), .cnt_clr(cnt_clr), .tdr_wr_sel(tdr_wr_sel),
    .prdata(prdata_o[2]), .pready(pready_o[2]), .pslverr(pslverr_o[2]), .snap_valid(snap_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc   = 0;
  logic        cnt_run = 1'b0;

  // Model state per instance
  logic        m_snap [3];
  logic [31:0] m_shadow [3];
  logic [31:0] exp_data;
  logic        exp_err;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] cnt;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_snap;
  } vec_t;

  vec_t vecs[$];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_snap[j]   = 1'b0;
      m_shadow[j] = 32'd0;
    end
  endtask

  // One clock edge: model update from pre-edge inputs, then sample after the edge
  task automatic clk_edge(input int cap_k);
    logic [9:0] off;
    off = paddr[11:2];
    if (cap_k >= 0) begin
      exp_err  = 1'b0;
      exp_data = 32'd0;
      if (off == 10'd0)      exp_data = cnt[31:0];
      else if (off == 10'd1) exp_data = m_snap[cap_k] ? m_shadow[cap_k] : cnt[63:32];
      else if (off == 10'd2) exp_data = {31'd0, m_snap[cap_k]};
      else                   exp_err  = 1'b1;
    end
    for (int j = 0; j < 3; j++) begin
      if (cnt_clr) begin
        m_snap[j]   = 1'b0;
        m_shadow[j] = 32'd0;
      end else if (tdr_wr_sel) begin
        m_snap[j] = 1'b0;
      end else if (j == cap_k && off == 10'd0) begin
        m_shadow[j] = cnt[63:32];
        m_snap[j]   = 1'b1;
      end else if (j == cap_k && off == 10'd1) begin
        m_snap[j] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    cnt_clr    = 1'b0;
    tdr_wr_sel = 1'b0;
    if (cnt_run) cnt = cnt + 64'd1;
    for (int j = 0; j < 3; j++) chk("snap_valid", 64'(snap_o[j]), 64'(m_snap[j]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_edge(-1);
  endtask

  task automatic apb_read(input int k, input logic [11:0] addr, input logic clr_cap,
                          input logic wr_cap, output logic [31:0] d, output logic e,
                          output logic s, output int rcyc);
    int ws;
    ws = ws_of(k);
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = addr;
    for (int n = 1; n <= ws + 1; n++) begin
      if (n == ws + 1) begin
        cnt_clr    = clr_cap;
        tdr_wr_sel = wr_cap;
      end
      clk_edge((n == ws + 1) ? k : -1);
      penable = 1'b1;
      chk("pready_timing", 64'(pready_o[k]), 64'(n == ws + 1));
      if (n <= ws) chk("pslverr_wait", 64'(pslverr_o[k]), 64'd0);
    end
    d    = prdata_o[k];
    e    = pslverr_o[k];
    s    = snap_o[k];
    rcyc = cyc;
    chk("prdata_model", 64'(d), 64'(exp_data));
    chk("pslverr_model", 64'(e), 64'(exp_err));
    clk_edge(-1);
    chk("pready_drop", 64'(pready_o[k]), 64'd0);
    chk("pslverr_drop", 64'(pslverr_o[k]), 64'd0);
    chk("prdata_hold", 64'(prdata_o[k]), 64'(exp_data));
    psel_v[k] = 1'b0;
    penable   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic        s;
    int          rc;
    int          rcs [4];

    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) psel_v[j] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = 12'd0;
    cnt = 64'd0; cnt_clr = 1'b0; tdr_wr_sel = 1'b0;
    model_reset();
    #3;
    for (int j = 0; j < 3; j++) begin
      chk("rst_prdata", 64'(prdata_o[j]), 64'd0);
      chk("rst_pready", 64'(pready_o[j]), 64'd0);
      chk("rst_pslverr", 64'(pslverr_o[j]), 64'd0);
      chk("rst_snap", 64'(snap_o[j]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, replayed on each wait-state variant
    vecs.push_back('{12'h004, 64'hDEAD_BEEF_0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{12'h008, 64'hDEAD_BEEF_0000_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{12'h00C, 64'hDEAD_BEEF_0000_0000, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{12'h000, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, 1'b0, 1'b1});
    vecs.push_back('{12'h008, 64'h1234_5678_9ABC_DEF0, 32'h0000_0001, 1'b0, 1'b1});
    vecs.push_back('{12'h00C, 64'hFFFF_FFFF_0000_0001, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{12'h004, 64'hFFFF_FFFF_0000_0001, 32'h1234_5678, 1'b0, 1'b0});
    vecs.push_back('{12'h004, 64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{12'h003, 64'hFFFF_FFFF_0000_0001, 32'h0000_0001, 1'b0, 1'b1});
    vecs.push_back('{12'h406, 64'hFFFF_FFFF_0000_0001, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{12'h007, 64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      foreach (vecs[i]) begin
        cnt = vecs[i].cnt;
        apb_read(k, vecs[i].addr, 1'b0, 1'b0, d, e, s, rc);
        chk("tbl_prdata", 64'(d), 64'(vecs[i].exp_data));
        chk("tbl_pslverr", 64'(e), 64'(vecs[i].exp_err));
        chk("tbl_snap", 64'(s), 64'(vecs[i].exp_snap));
      end
    end

    // Coherent pair across a carry into the upper half (1 wait state)
    cnt = 64'h0000_0001_FFFF_FFF0;
    cnt_run = 1'b1;
    apb_read(1, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    chk("carry_tdr0", 64'(d), 64'h0000_0000_FFFF_FFF1);
    chk("carry_snap_set", 64'(s), 64'd1);
    idle(20);
    apb_read(1, 12'h004, 1'b0, 1'b0, d, e, s, rc);
    chk("carry_tdr1", 64'(d), 64'h0000_0000_0000_0001);
    chk("carry_snap_clr", 64'(s), 64'd0);
    cnt_run = 1'b0;

    // Clear pulse, write strobe, and same-edge interactions (0 wait states)
    cnt = 64'h0000_0077_0000_0010;
    apb_read(0, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    cnt_clr = 1'b1;
    clk_edge(-1);
    cnt = 64'd0;
    chk("clr_snap", 64'(snap_o[0]), 64'd0);
    apb_read(0, 12'h004, 1'b0, 1'b0, d, e, s, rc);
    chk("clr_tdr1_live", 64'(d), 64'd0);
    cnt = 64'h0000_0099_0000_0020;
    apb_read(0, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    tdr_wr_sel = 1'b1;
    clk_edge(-1);
    chk("wrsel_snap", 64'(snap_o[0]), 64'd0);
    cnt = 64'h0000_00AB_0000_0000;
    apb_read(0, 12'h004, 1'b0, 1'b0, d, e, s, rc);
    chk("wrsel_tdr1_live", 64'(d), 64'h0000_0000_0000_00AB);
    cnt = 64'h0000_0055_0000_0033;
    apb_read(0, 12'h000, 1'b1, 1'b0, d, e, s, rc);
    chk("clr_tdr0_same_edge", 64'(d), 64'h33);
    chk("clr_tdr0_snap", 64'(s), 64'd0);
    apb_read(0, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    apb_read(0, 12'h004, 1'b1, 1'b0, d, e, s, rc);
    chk("clr_tdr1_same_edge", 64'(d), 64'h55);

    // Write transfers never complete here
    psel_v[1] = 1'b1; pwrite = 1'b1; paddr = 12'h000;
    clk_edge(-1);
    penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("write_no_pready", 64'(pready_o[1]), 64'd0);
      clk_edge(-1);
    end
    psel_v[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;

    // Abort in the second wait cycle (3 wait states)
    cnt = 64'h0000_0C0C_0000_0001;
    apb_read(2, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    psel_v[2] = 1'b1; penable = 1'b0; paddr = 12'h004;
    clk_edge(-1);
    penable = 1'b1;
    clk_edge(-1);
    psel_v[2] = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_edge(-1);
      chk("abort_no_pready", 64'(pready_o[2]), 64'd0);
    end
    chk("abort_snap_kept", 64'(snap_o[2]), 64'd1);
    cnt = 64'h0000_0D0D_0000_0000;
    apb_read(2, 12'h004, 1'b0, 1'b0, d, e, s, rc);
    chk("abort_then_tdr1", 64'(d), 64'h0C0C);

    // Back-to-back reads, pready every WAIT_STATES+2 cycles
    for (int i = 0; i < 4; i++) begin
      apb_read(2, 12'((i % 3) * 4), 1'b0, 1'b0, d, e, s, rcs[i]);
    end
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(rcs[i] - rcs[i-1]), 64'd5);

    // Asynchronous reset in the middle of a wait
    cnt = 64'h0000_2222_0000_1111;
    apb_read(2, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    psel_v[2] = 1'b1; penable = 1'b0; paddr = 12'h004;
    clk_edge(-1);
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pready", 64'(pready_o[2]), 64'd0);
    chk("arst_prdata", 64'(prdata_o[2]), 64'd0);
    chk("arst_snap", 64'(snap_o[2]), 64'd0);
    psel_v[2] = 1'b0; penable = 1'b0;
    idle(2);
    rst_n = 1'b1;
    clk_edge(-1);
    cnt = 64'h0000_3333_0000_4444;
    apb_read(2, 12'h000, 1'b0, 1'b0, d, e, s, rc);
    chk("post_rst_tdr0", 64'(d), 64'h4444);
    chk("post_rst_snap", 64'(s), 64'd1);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      int k;
      logic [11:0] a;
      k = int'($urandom_range(0, 2));
      case ($urandom % 5)
        0: a = 12'h000;
        1: a = 12'h004;
        2: a = 12'h008;
        3: a = 12'h00C;
        default: a = 12'($urandom);
      endcase
      a = {a[11:2], 2'($urandom)};
      if ($urandom % 4 == 0) cnt = {$urandom, $urandom};
      cnt_run = 1'($urandom);
      apb_read(k, a, ($urandom % 6) == 0, ($urandom % 6) == 0, d, e, s, rc);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        cnt_clr    = ($urandom % 8) == 0;
        tdr_wr_sel = ($urandom % 8) == 0;
        clk_edge(-1);
      end
    end
    cnt_run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_rd_port.md
# timer_rd_port

Read-side APB responder for the 64-bit timer counter. It returns TDR0 (`cnt[31:0]`), TDR1 (`cnt[63:32]`) and a status word, using a programmable number of wait states. Reading TDR0 snapshots the upper half so a following TDR1 read is coherent with it. It sits beside the counter's write path inside timer_ip and answers only read transfers (`pwrite=0`); write transfers are completed by the write path.

## Interface
- `WAIT_STATES`, default 1: access-phase cycles with `pready=0` before the completion cycle; legal range 0–7.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `psel` input 1: APB select.
- `penable` input 1: APB enable (access phase).
- `pwrite` input 1: APB direction; this block acts only when 0.
- `paddr` input 12: APB byte address; bits [1:0] are ignored.
- `cnt` input 64: live counter value.
- `cnt_clr` input 1: counter clear pulse.
- `tdr_wr_sel` input 1: write-path strobe, high when TDR0 or TDR1 is written.
- `prdata` output 32: read data; valid only while `pready=1`.
- `pready` output 1: transfer completion for read transfers.
- `pslverr` output 1: error response; valid only while `pready=1`.
- `snap_valid` output 1: the upper-half shadow holds an unread snapshot.

## Operation
- Register map, offset taken from `paddr[11:2]`:
  - 0x000 TDR0: returns `cnt[31:0]`; loads `hi_shadow <= cnt[63:32]` and sets `snap_valid`.
  - 0x004 TDR1: returns `hi_shadow` and clears `snap_valid` if `snap_valid=1`; otherwise returns `cnt[63:32]`.
  - 0x008 SNAP: returns {31'b0, `snap_valid`}; no side effects.
  - Any other offset: returns 0 with `pslverr=1` and no side effects.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on `psel=1`, `penable=0`, `pwrite=0` (setup phase):
    - If `WAIT_STATES=0`, perform the capture at this edge and go to RESP.
    - Otherwise load `wcnt=WAIT_STATES` and go to WAIT.
  - WAIT: if `psel=0`, abort to IDLE with no capture and no side effects. Otherwise decrement `wcnt`. At the edge where `wcnt==1`, perform the capture and go to RESP.
  - RESP: `pready=1` for exactly one cycle, then go to IDLE.
- Capture means, at one clock edge: register `prdata`, `pslverr` and the shadow/`snap_valid` update, all using the `cnt` value present before that edge.
- Write transfers (`pwrite=1`) leave the FSM in IDLE. This block never drives `pready=1` for writes.
- Shadow maintenance priority, highest first:
  1. `cnt_clr`: clears `hi_shadow` to 0 and `snap_valid` to 0. This wins over a same-edge TDR0 capture, but `prdata` still returns the pre-clear `cnt[31:0]`.
  2. `tdr_wr_sel`: clears `snap_valid`; `hi_shadow` is unchanged.
  3. Capture side effects (TDR0 sets, TDR1 clears).
- A TDR1 capture on the same edge as `cnt_clr` returns the pre-clear `hi_shadow`.
- `wcnt` is 3 bits wide and never wraps; WAIT is exited at the `wcnt==1` edge.

## Timing
- Reset values: `prdata=0`, `pready=0`, `pslverr=0`, `snap_valid=0`, `hi_shadow=0`, state IDLE, `wcnt=0`.
- With the setup phase in cycle T0, `pready=1` in cycle T0+1+`WAIT_STATES`.
  - `WAIT_STATES=1`: `pready` is 0 in T1 and 1 in T2.
  - `WAIT_STATES=0`: `pready` is 1 in T1.
- `prdata` reflects `cnt` sampled at the capture edge, one cycle before the `pready` cycle. It holds its last value outside RESP.
- `pslverr` is 0 whenever `pready=0`.
- Back-to-back reads: a setup phase in the cycle after RESP is accepted from IDLE, so there are no bubble cycles beyond the APB minimum.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronous), state returns to IDLE and the transfer is dropped.

## Test plan
- `WAIT_STATES=1`, `cnt=0x0000_0001_FFFF_FFF0` incrementing each cycle. Read TDR0 → `pready` high 2 cycles after setup; `prdata` equals the low word at the capture edge; `snap_valid=1`. Then read TDR1 → `prdata=0x0000_0001` even though the counter has carried into the upper half since the TDR0 read; `snap_valid=0`.
- Read TDR1 with `snap_valid=0` and `cnt=0xDEAD_BEEF_0000_0000` → `prdata=0xDEADBEEF`; SNAP read returns 0.
- Read offset 0x00C → `prdata=0`, `pslverr=1` for one cycle; `snap_valid` unchanged.
- Read TDR0, then pulse `cnt_clr` → `snap_valid=0`; TDR1 read returns live `cnt[63:32]` (0 after the clear). Repeat with `tdr_wr_sel` in place of `cnt_clr`: same `snap_valid` result, `hi_shadow` kept.
- `WAIT_STATES=3`: drop `psel` in the second WAIT cycle → no `pready`, `snap_valid` unchanged. Next, four back-to-back reads complete with `pready` spaced 5 cycles apart.
- Assert `rst_n=0` while in WAIT → `pready`, `prdata`, `snap_valid` are 0 at once; after release, a TDR0 read completes normally.
